// File: rtl/acceso_memoria_datos.sv
// Load/store access unit: byte-addressed requests to a word-indexed 32-bit memory,
// with read-modify-write for sub-word stores and sign/zero extension for sub-word loads.
module acceso_memoria_datos #(
  parameter int unsigned ANCHO_DIR  = 8,
  parameter int unsigned ANCHO_DATO = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  Req,
  input  logic                  Escr,
  input  logic [1:0]            Tam,
  input  logic                  SignExt,
  input  logic [ANCHO_DIR+1:0]  DirByte,
  input  logic [ANCHO_DATO-1:0] DatoEscr,
  output logic [ANCHO_DATO-1:0] DatoLeido,
  output logic                  Listo,
  output logic                  ErrAlin,
  output logic                  Ocupado,
  output logic                  EscrMem,
  output logic                  LeerMem,
  output logic [ANCHO_DIR-1:0]  Direc,
  output logic [ANCHO_DATO-1:0] Datain,
  input  logic [ANCHO_DATO-1:0] Dataout
);

  typedef enum logic [2:0] {
    StIdle,
    StLeer,
    StCaptura,
    StFusion,
    StEscribir,
    StFin
  } estado_e;

  estado_e     estado;
  logic        escr_q;
  logic [1:0]  tam_q;
  logic        sext_q;
  logic [1:0]  lane_q;
  logic [15:0] dato_q;

  logic        desalineado;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] lane_ext;
  logic [31:0] fusion;

  // Tam = 11 behaves as a word access.
  always_comb begin
    desalineado = ((Tam == 2'b01) && DirByte[0]) || (Tam[1] && (DirByte[1:0] != 2'b00));
  end

  always_comb begin
    byte_v = Dataout[7:0];
    unique case (lane_q)
      2'd0: byte_v = Dataout[7:0];
      2'd1: byte_v = Dataout[15:8];
      2'd2: byte_v = Dataout[23:16];
      2'd3: byte_v = Dataout[31:24];
      default: byte_v = Dataout[7:0];
    endcase
    half_v = lane_q[1] ? Dataout[31:16] : Dataout[15:0];

    unique case (tam_q)
      2'b00:   lane_ext = {{24{sext_q & byte_v[7]}}, byte_v};
      2'b01:   lane_ext = {{16{sext_q & half_v[15]}}, half_v};
      default: lane_ext = Dataout;
    endcase
  end

  always_comb begin
    fusion = Dataout;
    if (tam_q == 2'b00) begin
      unique case (lane_q)
        2'd0: fusion[7:0]   = dato_q[7:0];
        2'd1: fusion[15:8]  = dato_q[7:0];
        2'd2: fusion[23:16] = dato_q[7:0];
        2'd3: fusion[31:24] = dato_q[7:0];
        default: fusion = Dataout;
      endcase
    end else if (tam_q == 2'b01) begin
      if (lane_q[1]) fusion[31:16] = dato_q;
      else           fusion[15:0]  = dato_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado    <= StIdle;
      escr_q    <= 1'b0;
      tam_q     <= 2'b00;
      sext_q    <= 1'b0;
      lane_q    <= 2'b00;
      dato_q    <= '0;
      DatoLeido <= '0;
      Listo     <= 1'b0;
      ErrAlin   <= 1'b0;
      Ocupado   <= 1'b0;
      EscrMem   <= 1'b0;
      LeerMem   <= 1'b0;
      Direc     <= '0;
      Datain    <= '0;
    end else begin
      Listo   <= 1'b0;
      ErrAlin <= 1'b0;
      EscrMem <= 1'b0;
      LeerMem <= 1'b0;
      unique case (estado)
        StIdle: begin
          if (Req) begin
            escr_q  <= Escr;
            tam_q   <= Tam;
            sext_q  <= SignExt;
            lane_q  <= DirByte[1:0];
            dato_q  <= DatoEscr[15:0];
            Direc   <= DirByte[ANCHO_DIR+1:2];
            Ocupado <= 1'b1;
            if (desalineado) begin
              estado  <= StFin;
              Listo   <= 1'b1;
              ErrAlin <= 1'b1;
            end else if (Escr && Tam[1]) begin
              estado  <= StEscribir;
              EscrMem <= 1'b1;
              Datain  <= DatoEscr;
            end else begin
              estado  <= StLeer;
              LeerMem <= 1'b1;
            end
          end
        end
        StLeer: begin
          estado <= escr_q ? StFusion : StCaptura;
        end
        StCaptura: begin
          DatoLeido <= lane_ext;
          estado    <= StFin;
          Listo     <= 1'b1;
        end
        StFusion: begin
          Datain  <= fusion;
          estado  <= StEscribir;
          EscrMem <= 1'b1;
        end
        StEscribir: begin
          estado <= StFin;
          Listo  <= 1'b1;
        end
        StFin: begin
          estado  <= StIdle;
          Ocupado <= 1'b0;
        end
        default: begin
          estado  <= StIdle;
          Ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acceso_memoria_datos.sv
// Directed bench for acceso_memoria_datos with a 256-word memory model and a result scoreboard.
module tb_acceso_memoria_datos;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        Req = 1'b0;
  logic        Escr = 1'b0;
  logic [1:0]  Tam = 2'b00;
  logic        SignExt = 1'b0;
  logic [9:0]  DirByte = '0;
  logic [31:0] DatoEscr = '0;
  logic [31:0] DatoLeido;
  logic        Listo, ErrAlin, Ocupado, EscrMem, LeerMem;
  logic [7:0]  Direc;
  logic [31:0] Datain;
  logic [31:0] Dataout;

  typedef struct {
    logic [31:0] dato;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] last_d = '0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (EscrMem) mem[Direc] <= Datain;
    else if (LeerMem) Dataout <= mem[Direc];
  end

  acceso_memoria_datos #(.ANCHO_DIR(8), .ANCHO_DATO(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .Req       (Req),
    .Escr      (Escr),
    .Tam       (Tam),
    .SignExt   (SignExt),
    .DirByte   (DirByte),
    .DatoEscr  (DatoEscr),
    .DatoLeido (DatoLeido),
    .Listo     (Listo),
    .ErrAlin   (ErrAlin),
    .Ocupado   (Ocupado),
    .EscrMem   (EscrMem),
    .LeerMem   (LeerMem),
    .Direc     (Direc),
    .Datain    (Datain),
    .Dataout   (Dataout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_datoleido"}, DatoLeido, 32'h0);
    check({tag, "_listo"}, {31'b0, Listo}, 32'h0);
    check({tag, "_erralin"}, {31'b0, ErrAlin}, 32'h0);
    check({tag, "_ocupado"}, {31'b0, Ocupado}, 32'h0);
    check({tag, "_escrmem"}, {31'b0, EscrMem}, 32'h0);
    check({tag, "_leermem"}, {31'b0, LeerMem}, 32'h0);
    check({tag, "_direc"}, {24'b0, Direc}, 32'h0);
    check({tag, "_datain"}, Datain, 32'h0);
  endtask

  // One request; hold keeps Req high and scrambles fields while busy.
  task automatic op(input logic e, input logic [1:0] t, input logic s, input logic [9:0] a,
                    input logic [31:0] d, input bit hold);
    logic        misal;
    logic [31:0] word, shifted, mask, exp_w;
    int          sh, lat, leer, escr;
    exp_t        x, got;
    misal   = ((t == 2'b01) && a[0]) || (t[1] && (a[1:0] != 2'b00));
    word    = ref_mem[a[9:2]];
    sh      = int'(a[1:0]) * 8;
    shifted = word >> sh;
    exp_w   = '0;
    x.dato  = last_d;
    x.err   = 1'b0;
    leer    = 0;
    escr    = 0;
    if (misal) begin
      lat   = 1;
      x.err = 1'b1;
    end else if (!e) begin
      lat  = 3;
      leer = 1;
      if (t == 2'b00)      x.dato = {{24{s & shifted[7]}}, shifted[7:0]};
      else if (t == 2'b01) x.dato = {{16{s & shifted[15]}}, shifted[15:0]};
      else                 x.dato = word;
      last_d = x.dato;
    end else if (t[1]) begin
      lat   = 2;
      escr  = 1;
      exp_w = d;
      ref_mem[a[9:2]] = d;
    end else begin
      lat   = 4;
      leer  = 1;
      escr  = 3;
      mask  = ((t == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
      exp_w = (word & ~mask) | ((d << sh) & mask);
      ref_mem[a[9:2]] = exp_w;
    end
    x.lat = lat;
    sb.push_back(x);

    @(negedge clk);
    check("idle_ocupado", {31'b0, Ocupado}, 32'h0);
    Req = 1'b1; Escr = e; Tam = t; SignExt = s; DirByte = a; DatoEscr = d;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      check($sformatf("leermem_c%0d", c), {31'b0, LeerMem}, {31'b0, c == leer});
      check($sformatf("escrmem_c%0d", c), {31'b0, EscrMem}, {31'b0, c == escr});
      check($sformatf("ocupado_c%0d", c), {31'b0, Ocupado}, 32'h1);
      check($sformatf("listo_c%0d", c), {31'b0, Listo}, {31'b0, c == lat});
      if (c == leer || c == escr) check("direc", {24'b0, Direc}, {24'b0, a[9:2]});
      if (c == escr) check("datain", Datain, exp_w);
      if (Listo && sb.size() > 0) begin
        got = sb.pop_front();
        check("latencia", c, got.lat);
        check("datoleido", DatoLeido, got.dato);
        check("erralin", {31'b0, ErrAlin}, {31'b0, got.err});
      end
      if (hold) begin
        Escr = 1'($urandom); Tam = 2'($urandom); SignExt = 1'($urandom);
        DirByte = 10'($urandom); DatoEscr = $urandom;
      end else begin
        Req = 1'b0;
      end
    end
    check("listo_visto", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;

    op(1'b1, 2'b10, 1'b0, 10'h010, 32'hDEAD_BEEF, 1'b0);
    op(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 1'b0);
    op(1'b1, 2'b10, 1'b0, 10'h010, 32'h1122_3344, 1'b0);
    op(1'b1, 2'b00, 1'b0, 10'h013, 32'h0000_00AA, 1'b0);
    op(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 1'b0);

    op(1'b1, 2'b10, 1'b0, 10'h020, 32'h0000_80F0, 1'b0);
    op(1'b0, 2'b00, 1'b1, 10'h020, 32'h0, 1'b0);
    op(1'b0, 2'b00, 1'b0, 10'h020, 32'h0, 1'b0);
    op(1'b0, 2'b01, 1'b1, 10'h020, 32'h0, 1'b0);
    op(1'b0, 2'b01, 1'b0, 10'h022, 32'h0, 1'b0);
    op(1'b0, 2'b11, 1'b1, 10'h020, 32'h0, 1'b0);

    op(1'b0, 2'b10, 1'b0, 10'h011, 32'h0, 1'b0);
    op(1'b1, 2'b01, 1'b0, 10'h021, 32'h0000_FFFF, 1'b0);
    op(1'b0, 2'b10, 1'b0, 10'h020, 32'h0, 1'b0);

    op(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 1'b1);
    op(1'b0, 2'b00, 1'b1, 10'h021, 32'h0, 1'b1);
    Req = 1'b0;

    op(1'b1, 2'b10, 1'b0, 10'h3FC, 32'hCAFE_F00D, 1'b0);
    op(1'b1, 2'b00, 1'b0, 10'h3FF, 32'h0000_007E, 1'b0);
    op(1'b0, 2'b00, 1'b1, 10'h3FF, 32'h0, 1'b0);
    op(1'b0, 2'b10, 1'b0, 10'h3FC, 32'h0, 1'b0);

    // Reset during ESCRIBIR of a byte store must leave memory untouched.
    op(1'b1, 2'b10, 1'b0, 10'h040, 32'h1234_5678, 1'b0);
    @(negedge clk);
    Req = 1'b1; Escr = 1'b1; Tam = 2'b00; SignExt = 1'b0; DirByte = 10'h040;
    DatoEscr = 32'h0000_0055;
    @(negedge clk);
    Req = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_escrmem_antes", {31'b0, EscrMem}, 32'h1);
    check("rst_datain_antes", Datain, 32'h1234_5655);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_medio");
    @(posedge clk);
    #1;
    check("rst_mem_intacta", mem[8'h10], 32'h1234_5678);
    @(negedge clk);
    reset_n = 1'b1;
    last_d = '0;
    op(1'b0, 2'b10, 1'b0, 10'h040, 32'h0, 1'b0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/acceso_memoria_datos.md
# acceso_memoria_datos

Load/store access unit between the single-cycle datapath and the 256 x 32-bit data memory. It takes byte-addressed load/store requests of byte, halfword or word size. It converts them into the word-indexed read/write strobes the memory expects and performs read-modify-write for sub-word stores. It also extracts and sign/zero-extends sub-word loads, and flags misaligned accesses. It stalls the datapath through `Ocupado` while a request is in flight.

## Interface
- `ANCHO_DIR`, 8: memory word-index width; the byte address is `ANCHO_DIR+2` bits.
- `ANCHO_DATO`, 32: data word width; fixed at 32 in this design.
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `Req`  in  1  request; sampled only while idle.
- `Escr`  in  1  1 = store, 0 = load.
- `Tam`  in  2  size: 00 byte, 01 halfword, 10 word; 11 treated as word.
- `SignExt`  in  1  sign-extend sub-word loads when 1; zero-extend when 0.
- `DirByte`  in  10  byte address; word index = `DirByte[9:2]`.
- `DatoEscr`  in  32  store data; the sub-word value is in the low bits.
- `DatoLeido`  out  32  extended load result, registered; holds until the next successful load.
- `Listo`  out  1  one-cycle completion pulse.
- `ErrAlin`  out  1  misalignment flag; valid together with `Listo`.
- `Ocupado`  out  1  high whenever the state is not IDLE.
- `EscrMem`  out  1  memory write strobe.
- `LeerMem`  out  1  memory read strobe.
- `Direc`  out  8  memory word index.
- `Datain`  out  32  memory write data.
- `Dataout`  in  32  memory read data; it updates on the edge where `LeerMem=1` and `EscrMem=0`, and holds otherwise.

## Operation
- States: IDLE, LEER, CAPTURA, FUSION, ESCRIBIR, FIN.
- IDLE: when `Req=1`, the unit registers `Escr`, `Tam`, `SignExt`, `DirByte` and `DatoEscr`. The next state depends on the request:
  - Misaligned request (halfword with `DirByte[0]=1`, or word with `DirByte[1:0]!=0`): go to FIN with `ErrAlin` set. No memory strobe is issued and `DatoLeido` is unchanged.
  - Load: go to LEER.
  - Word store: go to ESCRIBIR.
  - Byte or halfword store: go to LEER.
- LEER: `LeerMem=1`. Next state is CAPTURA for a load, FUSION for a store.
- CAPTURA: register the selected lane into `DatoLeido`, then go to FIN.
  - Byte lane = `DirByte[1:0]`; byte 0 is `[7:0]` (little-endian).
  - Halfword lane = `DirByte[1]`; 0 selects `[15:0]`, 1 selects `[31:16]`.
  - Extension is sign or zero according to `SignExt`.
- FUSION: register a merged word. The merged word is `Dataout` with the addressed byte or halfword lane replaced by the low bits of `DatoEscr`. Then go to ESCRIBIR.
- ESCRIBIR: `EscrMem=1`. `Datain` is the merged word, or `DatoEscr` for a word store. Then go to FIN.
- FIN: `Listo=1`, then go to IDLE. `ErrAlin` is high in FIN only for misaligned requests.
- `Direc = DirByte[9:2]` from the captured request, held stable from LEER through ESCRIBIR.
- `EscrMem` and `LeerMem` are never both 1. Both are 0 in IDLE, CAPTURA and FIN.
- `Req` is ignored in every state other than IDLE. If `Req` is held high, the next request is accepted in the IDLE cycle after FIN.
- The byte address space covers exactly 256 words, so there is no wrap-around. `DirByte=0x3FF` maps to word 0xFF, byte 3.

## Timing
- Cycle 0 is the cycle in which IDLE samples `Req=1`.
- Load: LeerMem high in cycle 1, `DatoLeido` valid and `Listo` high in cycle 3; 4 cycles total.
- Word store: EscrMem high in cycle 1, `Listo` high in cycle 2.
- Sub-word store: LeerMem high in cycle 1, EscrMem high in cycle 3, `Listo` high in cycle 4.
- Misaligned request: `Listo` and `ErrAlin` high in cycle 1.
- Reset values: state IDLE; `DatoLeido=0`; `Listo`, `ErrAlin`, `Ocupado`, `EscrMem` and `LeerMem` all 0; `Direc=0`; `Datain=0`.
- Reset mid-operation: `reset_n` low forces the reset values immediately, with no clock required.
  - An in-flight write is abandoned. Because `EscrMem` is already 0 at the next edge, memory is not modified.
  - A write completed on an earlier edge stays in memory.

## Test plan
- Word store, then word load: store 0xDEADBEEF at 0x010, which gives one EscrMem cycle with `Direc=0x04` and `Listo` in cycle 2. Then load 0x010, which must give `DatoLeido=0xDEADBEEF` with `Listo` in cycle 3.
- Byte store read-modify-write: with word 0x04 holding 0x11223344, store byte 0xAA at 0x013. Expect LeerMem in cycle 1, EscrMem with `Datain=0xAA223344` in cycle 3, and `Listo` in cycle 4.
- Extension cases, with word 0x08 holding 0x000080F0:
  - signed byte load at 0x020 → 0xFFFFFFF0
  - unsigned byte load at 0x020 → 0x000000F0
  - signed halfword load at 0x020 → 0xFFFF80F0
  - unsigned halfword load at 0x022 → 0x00000000
- Misaligned word load at 0x011: `ErrAlin=1` and `Listo=1` in cycle 1. No LeerMem or EscrMem is issued, and `DatoLeido` keeps its previous value.
- `Req` held high across two back-to-back loads: the second request is accepted only in the IDLE cycle after FIN. Toggling the request fields while `Ocupado=1` must have no effect.
- Assert `reset_n` low during ESCRIBIR of a store of 0x55 to 0x040 over 0x12345678. `EscrMem` must drop immediately, word 0x10 must stay 0x12345678, and all outputs must go to their reset values.
